obstacle_generator: RTL and testbench

- Produces the packed obstacle buses consumed by the game logic; it is the producer side of that interface.
- Maintains 10 obstacle slots and spawns obstacles pseudo-randomly at the right screen edge.
- Scrolls obstacles left at a fixed rate and retires them once they leave the left edge.
- Reacts to `gamemode`: clear in initial, run in-game, freeze when paused or ended.

---
 rtl/obstacle_generator.sv | 191 +++++++++++++++++++
 tb/tb_obstacle_generator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/obstacle_generator.sv
// Obstacle producer: ten slots that spawn at the right screen edge from an LFSR,
// scroll left on a divided movement tick, and retire once past the left edge.
module obstacle_slot #(
  parameter int SPEED = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       tick,
  input  logic       load,
  input  logic [9:0] ld_xl,
  input  logic [9:0] ld_xr,
  input  logic [8:0] ld_yt,
  input  logic [8:0] ld_yb,
  output logic       act_q,
  output logic [9:0] xl_q,
  output logic [9:0] xr_q,
  output logic [8:0] yt_q,
  output logic [8:0] yb_q
);
  logic       act_d;
  logic [9:0] xl_d, xr_d;
  logic [8:0] yt_d, yb_d;

  always_comb begin
    act_d = act_q;
    xl_d  = xl_q;
    xr_d  = xr_q;
    yt_d  = yt_q;
    yb_d  = yb_q;
    if (clear) begin
      act_d = 1'b0;
      xl_d  = '0;
      xr_d  = '0;
      yt_d  = '0;
      yb_d  = '0;
    end else if (tick) begin
      if (load) begin
        act_d = 1'b1;
        xl_d  = ld_xl;
        xr_d  = ld_xr;
        yt_d  = ld_yt;
        yb_d  = ld_yb;
      end else if (act_q) begin
        if (xr_q < 10'(SPEED)) begin
          // Fully off the left edge: retire with all fields zeroed.
          act_d = 1'b0;
          xl_d  = '0;
          xr_d  = '0;
          yt_d  = '0;
          yb_d  = '0;
        end else begin
          xr_d = xr_q - 10'(SPEED);
          xl_d = (xl_q >= 10'(SPEED)) ? xl_q - 10'(SPEED) : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      xl_q  <= '0;
      xr_q  <= '0;
      yt_q  <= '0;
      yb_q  <= '0;
    end else begin
      act_q <= act_d;
      xl_q  <= xl_d;
      xr_q  <= xr_d;
      yt_q  <= yt_d;
      yb_q  <= yb_d;
    end
  end
endmodule

module obstacle_generator #(
  parameter int          TICK_DIV    = 416667,
  parameter int          SPAWN_TICKS = 90,
  parameter int          SPEED       = 4,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter int          MIN_W       = 32,
  parameter int          MIN_H       = 80,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   gamemode,
  output logic [199:0] obstacle_x,
  output logic [179:0] obstacle_y,
  output logic [9:0]   obstacle_active
);
  localparam int NUM_SLOTS = 10;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

  typedef enum logic [1:0] {GM_INIT, GM_RUN, GM_PAUSE, GM_END} gm_e;
  gm_e gm;
  assign gm = gm_e'(gamemode);

  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] spawn_cnt_q, spawn_cnt_d;
  logic          clear, tick, spawn_due, found;

  logic [NUM_SLOTS-1:0]      act, load_vec;
  logic [NUM_SLOTS-1:0][9:0] xl, xr;
  logic [NUM_SLOTS-1:0][8:0] yt, yb;

  logic [9:0] sp_w, sp_xr;
  logic [8:0] sp_h, sp_yt, sp_yb;

  assign clear     = (gm == GM_INIT);
  assign tick      = (gm == GM_RUN) && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign spawn_due = tick && (spawn_cnt_q == SW'(SPAWN_TICKS - 1));

  always_comb begin
    // x^16 + x^14 + x^13 + x^11 + 1, free-running in every mode.
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tick_cnt_d  = tick_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    if (clear) begin
      tick_cnt_d  = '0;
      spawn_cnt_d = '0;
    end else if (gm == GM_RUN) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) spawn_cnt_d = spawn_due ? '0 : spawn_cnt_q + 1'b1;
    end
  end

  // Lowest slot free at the start of the tick; retiring slots are still active here.
  always_comb begin
    load_vec = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!act[i] && !found) begin
        load_vec[i] = spawn_due;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sp_w  = 10'(MIN_W) + {4'd0, lfsr_q[5:0]};
    sp_xr = 10'(SCREEN_W) + sp_w - 10'd1;
    sp_h  = 9'(MIN_H) + {2'd0, lfsr_q[12:6]};
    if (lfsr_q[13]) begin
      sp_yt = 9'(SCREEN_H) - sp_h;
      sp_yb = 9'(SCREEN_H - 1);
    end else begin
      sp_yt = '0;
      sp_yb = sp_h - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= LFSR_SEED;
      tick_cnt_q  <= '0;
      spawn_cnt_q <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      tick_cnt_q  <= tick_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    obstacle_slot #(.SPEED(SPEED)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .tick  (tick),
      .load  (load_vec[i]),
      .ld_xl (10'(SCREEN_W)),
      .ld_xr (sp_xr),
      .ld_yt (sp_yt),
      .ld_yb (sp_yb),
      .act_q (act[i]),
      .xl_q  (xl[i]),
      .xr_q  (xr[i]),
      .yt_q  (yt[i]),
      .yb_q  (yb[i])
    );
    assign obstacle_x[20*i +: 20] = {xl[i], xr[i]};
    assign obstacle_y[18*i +: 18] = {yt[i], yb[i]};
  end

  assign obstacle_active = act;
endmodule

// File: tb/tb_obstacle_generator.sv
// Randomized gamemode stimulus against a slot-list reference model; every cycle
// the three output buses are compared, plus async-reset checks.
module tb_obstacle_generator;
  localparam int TICK_DIV = 4, SPAWN_TICKS = 3, SPEED = 4;
  localparam int SCREEN_W = 640, SCREEN_H = 480, MIN_W = 32, MIN_H = 80;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   gamemode;
  logic [199:0] obstacle_x;
  logic [179:0] obstacle_y;
  logic [9:0]   obstacle_active;

  obstacle_generator #(.TICK_DIV(TICK_DIV), .SPAWN_TICKS(SPAWN_TICKS), .SPEED(SPEED)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gamemode        (gamemode),
    .obstacle_x      (obstacle_x),
    .obstacle_y      (obstacle_y),
    .obstacle_active (obstacle_active)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain list of obstacles with integer coordinates.
  int   m_xl[10], m_xr[10], m_yt[10], m_yb[10];
  bit   m_act[10];
  int   m_tc, m_sc;
  logic [15:0] m_lf;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_act[i] = 0; m_xl[i] = 0; m_xr[i] = 0; m_yt[i] = 0; m_yb[i] = 0;
    end
    m_tc = 0; m_sc = 0; m_lf = SEED;
  endtask

  task automatic model_step(input int gm);
    bit tick, due;
    int tgt, w, h;
    tick = 0;
    if (gm == 0) begin
      for (int i = 0; i < 10; i++) begin
        m_act[i] = 0; m_xl[i] = 0; m_xr[i] = 0; m_yt[i] = 0; m_yb[i] = 0;
      end
      m_tc = 0; m_sc = 0;
    end else if (gm == 1) begin
      if (m_tc == TICK_DIV - 1) begin m_tc = 0; tick = 1; end
      else m_tc++;
    end
    if (tick) begin
      due = (m_sc == SPAWN_TICKS - 1);
      m_sc = due ? 0 : m_sc + 1;
      tgt = -1;
      for (int i = 9; i >= 0; i--) if (!m_act[i]) tgt = i;
      for (int i = 0; i < 10; i++) begin
        if (m_act[i]) begin
          if (m_xr[i] < SPEED) begin
            m_act[i] = 0; m_xl[i] = 0; m_xr[i] = 0; m_yt[i] = 0; m_yb[i] = 0;
          end else begin
            m_xr[i] -= SPEED;
            m_xl[i] = (m_xl[i] >= SPEED) ? m_xl[i] - SPEED : 0;
          end
        end
      end
      if (due && tgt >= 0) begin
        w = MIN_W + int'(m_lf % 64);
        h = MIN_H + int'((m_lf / 64) % 128);
        m_act[tgt] = 1;
        m_xl[tgt]  = SCREEN_W;
        m_xr[tgt]  = SCREEN_W + w - 1;
        if (m_lf[13]) begin m_yt[tgt] = SCREEN_H - h; m_yb[tgt] = SCREEN_H - 1; end
        else begin m_yt[tgt] = 0; m_yb[tgt] = h - 1; end
      end
    end
    m_lf = lfsr_adv(m_lf);
  endtask

  task automatic compare_all();
    logic [199:0] ex;
    logic [179:0] ey;
    logic [9:0]   ea;
    for (int i = 0; i < 10; i++) begin
      ex[20*i +: 20] = {10'(m_xl[i]), 10'(m_xr[i])};
      ey[18*i +: 18] = {9'(m_yt[i]), 9'(m_yb[i])};
      ea[i] = m_act[i];
    end
    chk("active", 200'(obstacle_active), 200'(ea));
    chk("obs_x", obstacle_x, ex);
    chk("obs_y", 200'(obstacle_y), 200'(ey));
  endtask

  task automatic step(input int gm);
    gamemode = 2'(gm);
    @(posedge clk);
    model_step(gm);
    #1 compare_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_active", 200'(obstacle_active), 200'd0);
    chk("rst_x", obstacle_x, 200'd0);
    chk("rst_y", 200'(obstacle_y), 200'd0);
    model_reset();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int r, mode, len;
    rst_n = 1'b0;
    gamemode = 2'b00;
    model_reset();
    #1;
    chk("init_active", 200'(obstacle_active), 200'd0);
    chk("init_x", obstacle_x, 200'd0);
    chk("init_y", 200'(obstacle_y), 200'd0);
    #11 rst_n = 1'b1;

    // Long run: saturation, dropped spawns, clamping and retirement.
    for (int c = 0; c < 1400; c++) step(1);
    for (int c = 0; c < 50; c++) step(2);
    for (int c = 0; c < 20; c++) step(1);
    for (int c = 0; c < 5; c++) step(3);
    step(0);
    for (int c = 0; c < 300; c++) step(1);
    async_reset();
    for (int c = 0; c < 200; c++) step(1);

    for (int seg = 0; seg < 150; seg++) begin
      r = $urandom_range(0, 99);
      mode = (r < 75) ? 1 : (r < 85) ? 2 : (r < 95) ? 3 : 0;
      len = (mode == 0) ? $urandom_range(1, 5) : $urandom_range(1, 60);
      for (int c = 0; c < len; c++) step(mode);
      if (seg == 90) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
